joystick_mapper: RTL and testbench

Parametrised successor to the two-port joystick protocol block. Maps NJOY digital joystick channels onto Kempston, Fuller, Sinclair P1/P2, Cursor and OPQA-Space-M protocols. Each channel has its own ZXUNO config register and a press-aligned autofire generator with selectable rate. Sits between the joystick/keyboard-joystick sources, the CPU I/O read mux and the keyboard column path.

---
 rtl/joystick_mapper_if.sv | 24 ++
 rtl/joystick_mapper.sv | 205 ++++++++++++++++++++
 tb/tb_joystick_mapper.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/joystick_mapper_if.sv
// CPU I/O and ZXUNO register bus as seen by the joystick mapper.
// The master side is the CPU/bus fabric; the slave side is the mapper.
`timescale 1ns/1ps
interface joystick_mapper_if;
  logic [15:0] a;
  logic        iorq_n;
  logic        rd_n;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        oe;
  logic [7:0]  zxuno_addr;
  logic        zxuno_regrd;
  logic        zxuno_regwr;

  modport master (
    output a, iorq_n, rd_n, din, zxuno_addr, zxuno_regrd, zxuno_regwr,
    input  dout, oe
  );

  modport slave (
    input  a, iorq_n, rd_n, din, zxuno_addr, zxuno_regrd, zxuno_regwr,
    output dout, oe
  );
endinterface

// File: rtl/joystick_mapper.sv
// Maps NJOY digital joystick channels onto Kempston, Fuller, Sinclair, Cursor
// and OPQA-Space-M, with a per-channel config register and press-aligned autofire.
`timescale 1ns/1ps
module joystick_mapper #(
  parameter int          NJOY          = 2,
  parameter logic [7:0]  JOYCONF_BASE  = 8'h06,
  parameter logic [7:0]  KEMPSTON_ADDR = 8'h1F,
  parameter logic [7:0]  FULLER_ADDR   = 8'h7F,
  parameter logic [7:0]  DEFAULT_CONF  = 8'h01
) (
  input  logic                 clk,
  input  logic                 rst_n,
  joystick_mapper_if.slave     bus,
  input  logic [6*NJOY-1:0]    joy_in,
  input  logic [4:0]           kbdcol_in,
  output logic [4:0]           kbdcol_out,
  input  logic                 vertical_retrace_int_n
);

  localparam logic [2:0] PROTO_KEMPSTON  = 3'd1;
  localparam logic [2:0] PROTO_SINCLAIR1 = 3'd2;
  localparam logic [2:0] PROTO_SINCLAIR2 = 3'd3;
  localparam logic [2:0] PROTO_CURSOR    = 3'd4;
  localparam logic [2:0] PROTO_FULLER    = 3'd5;
  localparam logic [2:0] PROTO_OPQA      = 3'd6;

  logic [7:0]        conf_r [NJOY];
  logic [3:0]        afc_r  [NJOY];
  logic [6*NJOY-1:0] joy_meta_r;
  logic [6*NJOY-1:0] joy_sync_r;
  logic [NJOY-1:0]   f1_prev_r;
  logic              vr_meta_r;
  logic              vr_sync_r;
  logic              vr_prev_r;

  logic [NJOY-1:0]   r_s, l_s, d_s, u_s, f1_s, f2_s, fire_s, hit_s;
  logic              vr_rise_s;
  logic              io_rd_s;
  logic [7:0]        kemp_s;
  logic [7:0]        full_s;
  logic [7:0]        sel_conf_s;
  logic [4:0]        kmask_s;
  logic [7:0]        dout_s;
  logic              oe_s;
  logic [4:0]        kbd_s;
  logic              unused_s;

  assign vr_rise_s = vr_sync_r & ~vr_prev_r;
  assign io_rd_s   = ~bus.iorq_n & ~bus.rd_n;
  assign unused_s  = bus.a[14];

  // Per-channel decode: active-high directions, optional F1/F2 swap, autofire gating.
  always_comb begin
    r_s    = '0;
    l_s    = '0;
    d_s    = '0;
    u_s    = '0;
    f1_s   = '0;
    f2_s   = '0;
    fire_s = '0;
    hit_s  = '0;
    for (int i = 0; i < NJOY; i++) begin
      r_s[i] = ~joy_sync_r[6*i];
      l_s[i] = ~joy_sync_r[6*i+1];
      d_s[i] = ~joy_sync_r[6*i+2];
      u_s[i] = ~joy_sync_r[6*i+3];
      if (conf_r[i][6]) begin
        f1_s[i] = ~joy_sync_r[6*i+5];
        f2_s[i] = ~joy_sync_r[6*i+4];
      end else begin
        f1_s[i] = ~joy_sync_r[6*i+4];
        f2_s[i] = ~joy_sync_r[6*i+5];
      end
      if (conf_r[i][3]) begin
        fire_s[i] = f1_s[i] & ~afc_r[i][conf_r[i][5:4]];
      end else begin
        fire_s[i] = f1_s[i];
      end
      hit_s[i] = (bus.zxuno_addr == (JOYCONF_BASE + 8'(i)));
    end
  end

  // Config registers, loaded from the ZXUNO write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NJOY; i++) begin
        conf_r[i] <= DEFAULT_CONF;
      end
    end else begin
      for (int i = 0; i < NJOY; i++) begin
        if (bus.zxuno_regwr && hit_s[i]) begin
          conf_r[i] <= bus.din;
        end else begin
          conf_r[i] <= conf_r[i];
        end
      end
    end
  end

  // Input synchronizers; reset to the released level so a held button re-aligns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      joy_meta_r <= '1;
      joy_sync_r <= '1;
      vr_meta_r  <= 1'b1;
      vr_sync_r  <= 1'b1;
      vr_prev_r  <= 1'b1;
    end else begin
      joy_meta_r <= joy_in;
      joy_sync_r <= joy_meta_r;
      vr_meta_r  <= vertical_retrace_int_n;
      vr_sync_r  <= vr_meta_r;
      vr_prev_r  <= vr_sync_r;
    end
  end

  // Autofire frame counters: held at zero until F1 has been held for a cycle,
  // so a press and a retrace edge in the same cycle still leaves the count at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f1_prev_r <= '0;
      for (int i = 0; i < NJOY; i++) begin
        afc_r[i] <= 4'd0;
      end
    end else begin
      f1_prev_r <= f1_s;
      for (int i = 0; i < NJOY; i++) begin
        if (!f1_s[i] || !f1_prev_r[i]) begin
          afc_r[i] <= 4'd0;
        end else if (vr_rise_s) begin
          afc_r[i] <= afc_r[i] + 4'd1;
        end else begin
          afc_r[i] <= afc_r[i];
        end
      end
    end
  end

  // Protocol combining and the read/keyboard output mux.
  always_comb begin
    kemp_s     = 8'h00;
    full_s     = 8'hFF;
    kmask_s    = 5'h1F;
    sel_conf_s = 8'h00;
    dout_s     = 8'hFF;
    oe_s       = 1'b0;
    kbd_s      = kbdcol_in;
    for (int i = 0; i < NJOY; i++) begin
      sel_conf_s = sel_conf_s | (hit_s[i] ? conf_r[i] : 8'h00);
      case (conf_r[i][2:0])
        PROTO_KEMPSTON: begin
          kemp_s = kemp_s | {2'b00, f2_s[i], fire_s[i], u_s[i], d_s[i], l_s[i], r_s[i]};
        end
        PROTO_FULLER: begin
          full_s = full_s & ~{fire_s[i], f2_s[i], 2'b00, r_s[i], l_s[i], d_s[i], u_s[i]};
        end
        PROTO_SINCLAIR1: begin
          kmask_s = kmask_s
                  & (bus.a[12] ? 5'h1F : ~{l_s[i], r_s[i], d_s[i], u_s[i], fire_s[i]})
                  & (bus.a[8]  ? 5'h1F : ~{2'b00, f2_s[i], 2'b00});
        end
        PROTO_SINCLAIR2: begin
          kmask_s = kmask_s
                  & (bus.a[11] ? 5'h1F : ~{fire_s[i], u_s[i], d_s[i], r_s[i], l_s[i]})
                  & (bus.a[8]  ? 5'h1F : ~{3'b000, f2_s[i], 1'b0});
        end
        PROTO_CURSOR: begin
          kmask_s = kmask_s
                  & (bus.a[12] ? 5'h1F : ~{d_s[i], u_s[i], r_s[i], f2_s[i], fire_s[i]})
                  & (bus.a[11] ? 5'h1F : ~{l_s[i], 4'b0000});
        end
        PROTO_OPQA: begin
          kmask_s = kmask_s
                  & (bus.a[13] ? 5'h1F : ~{3'b000, l_s[i], r_s[i]})
                  & (bus.a[10] ? 5'h1F : ~{4'b0000, u_s[i]})
                  & (bus.a[9]  ? 5'h1F : ~{4'b0000, d_s[i]})
                  & (bus.a[15] ? 5'h1F : ~{2'b00, f2_s[i], 1'b0, fire_s[i]});
        end
        default: begin
          kmask_s = kmask_s;
        end
      endcase
    end

    if (bus.zxuno_regrd && (|hit_s)) begin
      oe_s   = 1'b1;
      dout_s = sel_conf_s;
    end else if (io_rd_s && (bus.a[7:0] == KEMPSTON_ADDR)) begin
      oe_s   = 1'b1;
      dout_s = kemp_s;
    end else if (io_rd_s && (bus.a[7:0] == FULLER_ADDR)) begin
      oe_s   = 1'b1;
      dout_s = full_s;
    end else if (io_rd_s && !bus.a[0]) begin
      kbd_s = kbdcol_in & kmask_s;
    end else begin
      kbd_s = kbdcol_in;
    end
  end

  assign bus.dout   = dout_s;
  assign bus.oe     = oe_s;
  assign kbdcol_out = kbd_s;

endmodule

// File: tb/tb_joystick_mapper.sv
// Directed self-checking bench for joystick_mapper: config registers, protocol
// mapping, keyboard overlay, autofire cadence and reset behaviour.
`timescale 1ns/1ps
module tb_joystick_mapper;
  logic        clk;
  logic        rst_n;
  logic [11:0] joy_in;
  logic [4:0]  kbdcol_in;
  logic [4:0]  kbdcol_out;
  logic        vret;
  int          total;
  int          bad;
  logic [7:0]  af_exp [8];

  joystick_mapper_if bus ();

  joystick_mapper dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .bus                    (bus),
    .joy_in                 (joy_in),
    .kbdcol_in              (kbdcol_in),
    .kbdcol_out             (kbdcol_out),
    .vertical_retrace_int_n (vret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic zx_write(input logic [7:0] addr, input logic [7:0] data);
    bus.zxuno_addr  = addr;
    bus.din         = data;
    bus.zxuno_regwr = 1'b1;
    tick(1);
    bus.zxuno_regwr = 1'b0;
  endtask

  task automatic zx_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    bus.zxuno_addr  = addr;
    bus.zxuno_regrd = 1'b1;
    #1;
    check({tag, ".oe"}, {7'd0, bus.oe}, 8'h01);
    check(tag, bus.dout, exp);
    bus.zxuno_regrd = 1'b0;
  endtask

  task automatic io_check(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    bus.a      = addr;
    bus.iorq_n = 1'b0;
    bus.rd_n   = 1'b0;
    #1;
    check({tag, ".oe"}, {7'd0, bus.oe}, 8'h01);
    check(tag, bus.dout, exp);
    bus.iorq_n = 1'b1;
    bus.rd_n   = 1'b1;
  endtask

  task automatic kb_check(input string tag, input logic [15:0] addr,
                          input logic [4:0] kin, input logic [4:0] exp);
    bus.a      = addr;
    kbdcol_in  = kin;
    bus.iorq_n = 1'b0;
    bus.rd_n   = 1'b0;
    #1;
    check({tag, ".oe"}, {7'd0, bus.oe}, 8'h00);
    check(tag, {3'd0, kbdcol_out}, {3'd0, exp});
    bus.iorq_n = 1'b1;
    bus.rd_n   = 1'b1;
  endtask

  task automatic frame();
    vret = 1'b0;
    tick(3);
    vret = 1'b1;
    tick(3);
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    af_exp          = '{8'h10, 8'h10, 8'h00, 8'h00, 8'h10, 8'h10, 8'h00, 8'h00};
    rst_n           = 1'b0;
    joy_in          = 12'hFFF;
    kbdcol_in       = 5'h15;
    vret            = 1'b1;
    bus.a           = 16'h0000;
    bus.iorq_n      = 1'b1;
    bus.rd_n        = 1'b1;
    bus.din         = 8'h00;
    bus.zxuno_addr  = 8'h00;
    bus.zxuno_regrd = 1'b0;
    bus.zxuno_regwr = 1'b0;

    #1;
    check("rst.oe", {7'd0, bus.oe}, 8'h00);
    check("rst.dout", bus.dout, 8'hFF);
    check("rst.kbd", {3'd0, kbdcol_out}, 8'h15);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    zx_check("conf06.rst", 8'h06, 8'h01);
    zx_check("conf07.rst", 8'h07, 8'h01);
    zx_write(8'h07, 8'hC6);
    zx_check("conf07.wr", 8'h07, 8'hC6);
    zx_check("conf06.keep", 8'h06, 8'h01);
    zx_write(8'h08, 8'h55);
    zx_check("conf07.oob", 8'h07, 8'hC6);
    zx_write(8'h07, 8'h01);

    // Kempston on both channels
    joy_in = {6'b111111, 6'b011110};
    tick(1);
    io_check("kemp.lat1", 16'h001F, 8'h00);
    tick(1);
    io_check("kemp.ch0", 16'h001F, 8'h21);
    joy_in = {6'b110111, 6'b011110};
    tick(2);
    io_check("kemp.or", 16'h001F, 8'h29);

    // Fuller on channel 1
    zx_write(8'h07, 8'h05);
    joy_in = {6'b101101, 6'b111111};
    tick(2);
    io_check("fuller", 16'h007F, 8'h7B);
    zx_write(8'h07, 8'h01);
    io_check("fuller.none", 16'h007F, 8'hFF);
    io_check("kemp.f1l", 16'h001F, 8'h12);
    zx_write(8'h07, 8'h41);
    io_check("kemp.swap", 16'h001F, 8'h22);

    // Sinclair P1, Cursor and OPQA keyboard overlays on channel 0
    zx_write(8'h06, 8'h02);
    zx_write(8'h07, 8'h00);
    joy_in = {6'b111111, 6'b110111};
    tick(2);
    kb_check("sp1.up", 16'hEFFE, 5'h1F, 5'h1D);
    kb_check("sp1.row", 16'hF7FE, 5'h1F, 5'h1F);
    zx_write(8'h06, 8'h04);
    joy_in = {6'b111111, 6'b111101};
    tick(2);
    kb_check("cur.left", 16'hF7FE, 5'h1F, 5'h0F);
    kb_check("cur.pass", 16'hEFFE, 5'h1E, 5'h1E);
    zx_write(8'h06, 8'h06);
    joy_in = {6'b111111, 6'b101111};
    tick(2);
    kb_check("opqa.space", 16'h7FFE, 5'h1F, 5'h1E);

    // Autofire, R=1: fire for two frames, off for two
    zx_write(8'h06, 8'h19);
    joy_in = 12'hFFF;
    tick(3);
    joy_in = {6'b111111, 6'b101111};
    tick(2);
    for (int k = 0; k < 8; k++) begin
      io_check($sformatf("af.frame%0d", k), 16'h001F, af_exp[k]);
      if (k < 7) frame();
    end
    joy_in = 12'hFFF;
    tick(2);
    io_check("af.release", 16'h001F, 8'h00);
    joy_in = {6'b111111, 6'b101111};
    tick(2);
    io_check("af.repress", 16'h001F, 8'h10);
    frame();
    io_check("af.afc1", 16'h001F, 8'h10);
    zx_write(8'h06, 8'h09);
    io_check("af.rate0", 16'h001F, 8'h00);
    zx_write(8'h06, 8'h19);
    io_check("af.rate1", 16'h001F, 8'h10);

    // Reset while held
    rst_n = 1'b0;
    #1;
    io_check("rst.hold", 16'h001F, 8'h00);
    zx_check("rst.conf06", 8'h06, 8'h01);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    io_check("rst.lat1", 16'h001F, 8'h00);
    tick(1);
    io_check("rst.refire", 16'h001F, 8'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
